// File: rtl/intr_ctrl_pkg.sv
// Shared types and helpers for the sequential interrupt controller.
package intr_ctrl_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  localparam int CLS_A = 0;
  localparam int CLS_B = 1;
  localparam int CLS_C = 2;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/intr_pick.sv
// Combinational find-first-set over N bits, searching upward from start with wrap.
module intr_pick #(
  parameter int N = 9,
  parameter int W = 4
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  function automatic int wrap_pos(input int s, input int k);
    int j;
    j = s + k;
    return (j >= N) ? j - N : j;
  endfunction

  // Walk from the farthest offset back to the nearest so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (vec[wrap_pos(int'(start), k)]) begin
        found = 1'b1;
        idx   = W'(wrap_pos(int'(start), k));
      end
    end
  end

endmodule

// File: rtl/intr_ctrl_seq.sv
// Clocked interrupt controller: edge-captured pending flags, class/channel
// arbitration and a valid/ack handshake towards the CPU.
//
//   state   | meaning
//   IDLE    | nothing presented; latch the current winner if any is eligible
//   PRESENT | irq_cls/irq_ch held stable until irq_ack
module intr_ctrl_seq
  import intr_ctrl_pkg::*;
#(
  parameter int NCH  = 9,
  parameter int NCLS = 3,
  parameter int CHW  = $clog2(NCH),
  parameter int CLW  = clog2_min1(NCLS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       en,
  input  logic [NCLS*NCH-1:0]  req,
  input  logic                 rr_mode,
  output logic                 irq_valid,
  output logic [CLW-1:0]       irq_cls,
  output logic [CHW-1:0]       irq_ch,
  input  logic                 irq_ack,
  output logic [NCLS-1:0]      cls_active,
  output logic [NCLS*NCH-1:0]  pend
);

  localparam int NB = NCLS * NCH;

  state_t          state;
  logic            armed;
  logic [NB-1:0]   req_q;
  logic [NB-1:0]   rise;
  logic [NB-1:0]   clr;
  logic [NB-1:0]   elig;
  logic [CHW-1:0]  rr     [NCLS];
  logic [CHW-1:0]  ch_idx [NCLS];
  logic [NCLS-1:0] ch_found;
  logic            any_elig;
  logic [CLW-1:0]  win_cls;

  assign elig = pend & {NCLS{en}};

  // armed stays low for the first clock after reset so a request that is
  // already high when reset releases is treated as held, not as a new edge.
  assign rise = req & ~req_q & {NCLS{en}} & {NB{armed}};

  generate
    for (genvar c = 0; c < NCLS; c++) begin : gen_cls
      logic [CHW-1:0] start;
      assign start = !rr_mode ? '0 :
                     (rr[c] == CHW'(NCH - 1)) ? '0 : rr[c] + CHW'(1);
      intr_pick #(.N(NCH), .W(CHW)) u_pick (
        .vec   (elig[c*NCH +: NCH]),
        .start (start),
        .found (ch_found[c]),
        .idx   (ch_idx[c])
      );
    end
  endgenerate

  intr_pick #(.N(NCLS), .W(CLW)) u_cls_pick (
    .vec   (ch_found),
    .start ('0),
    .found (any_elig),
    .idx   (win_cls)
  );

  assign cls_active = ch_found;

  always_comb begin
    clr = '0;
    if (state == PRESENT && irq_ack) begin
      for (int c = 0; c < NCLS; c++) begin
        for (int i = 0; i < NCH; i++) begin
          if (irq_cls == CLW'(c) && irq_ch == CHW'(i)) clr[c*NCH+i] = 1'b1;
        end
      end
    end
  end

  // Set has priority over the ack clear on the same bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
      armed <= 1'b0;
      pend  <= '0;
    end else begin
      req_q <= req;
      armed <= 1'b1;
      pend  <= (pend & ~clr) | rise;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      irq_valid <= 1'b0;
      irq_cls   <= '0;
      irq_ch    <= '0;
      for (int c = 0; c < NCLS; c++) rr[c] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_elig) begin
            irq_cls   <= win_cls;
            irq_ch    <= ch_idx[win_cls];
            irq_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (irq_ack) begin
            rr[irq_cls] <= irq_ch;
            irq_valid   <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          irq_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intr_ctrl_seq.sv
// Randomized bench for intr_ctrl_seq against a cycle-level behavioural model.
module tb_intr_ctrl_seq;
  import intr_ctrl_pkg::*;

  localparam int NCH  = 9;
  localparam int NCLS = 3;
  localparam int CHW  = 4;
  localparam int CLW  = 2;
  localparam int NB   = NCH * NCLS;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NCH-1:0]  en = '1;
  logic [NB-1:0]   req = '0;
  logic            rr_mode = 1'b0;
  logic            irq_ack = 1'b0;
  logic            irq_valid;
  logic [CLW-1:0]  irq_cls;
  logic [CHW-1:0]  irq_ch;
  logic [NCLS-1:0] cls_active;
  logic [NB-1:0]   pend;

  intr_ctrl_seq #(.NCH(NCH), .NCLS(NCLS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .req        (req),
    .rr_mode    (rr_mode),
    .irq_valid  (irq_valid),
    .irq_cls    (irq_cls),
    .irq_ch     (irq_ch),
    .irq_ack    (irq_ack),
    .cls_active (cls_active),
    .pend       (pend)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  bit          pm [NCLS][NCH];
  bit [NB-1:0] reqq_m;
  bit          armed_m;
  int          rr_m [NCLS];
  bit          v_m;
  int          cls_m, ch_m;

  task automatic model_reset();
    for (int c = 0; c < NCLS; c++) begin
      rr_m[c] = 0;
      for (int i = 0; i < NCH; i++) pm[c][i] = 0;
    end
    reqq_m = '0; armed_m = 0; v_m = 0; cls_m = 0; ch_m = 0;
  endtask

  task automatic pick(output bit found, output int gc, output int gi);
    found = 0; gc = 0; gi = 0;
    for (int c = 0; c < NCLS; c++) begin
      for (int k = 0; k < NCH; k++) begin
        int i;
        i = rr_mode ? (rr_m[c] + 1 + k) % NCH : k;
        if (!found && pm[c][i] && en[i]) begin
          found = 1; gc = c; gi = i;
        end
      end
    end
  endtask

  task automatic model_clock();
    bit npm [NCLS][NCH];
    bit found;
    int gc, gi;
    found = 0; gc = 0; gi = 0;
    if (!v_m) pick(found, gc, gi);
    for (int c = 0; c < NCLS; c++)
      for (int i = 0; i < NCH; i++) begin
        npm[c][i] = pm[c][i];
        if (v_m && irq_ack && c == cls_m && i == ch_m) npm[c][i] = 0;
        if (armed_m && req[c*NCH+i] && !reqq_m[c*NCH+i] && en[i]) npm[c][i] = 1;
      end
    if (v_m && irq_ack) begin
      rr_m[cls_m] = ch_m;
      v_m = 0;
    end else if (!v_m && found) begin
      v_m = 1; cls_m = gc; ch_m = gi;
    end
    pm = npm;
    reqq_m = req;
    armed_m = 1;
  endtask

  task automatic compare();
    logic [NB-1:0]   ep;
    logic [NCLS-1:0] ea;
    ep = '0; ea = '0;
    for (int c = 0; c < NCLS; c++)
      for (int i = 0; i < NCH; i++) begin
        ep[c*NCH+i] = pm[c][i];
        if (pm[c][i] && en[i]) ea[c] = 1'b1;
      end
    check("irq_valid", irq_valid, v_m);
    if (v_m) begin
      check("irq_cls", irq_cls, cls_m);
      check("irq_ch", irq_ch, ch_m);
    end
    check("cls_active", cls_active, ea);
    check("pend", pend, ep);
  endtask

  task automatic cycle(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_clock();
      #1;
      compare();
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", irq_valid, 1'b0);
    check("rst_pend", pend, '0);
    check("rst_active", cls_active, '0);
    rst_n = 1'b1;
    cycle(2);

    // Single request on (B,3)
    req[CLS_B*NCH+3] = 1'b1;
    cycle();
    check("b3_pend", pend, 27'h1 << (CLS_B*NCH+3));
    check("b3_not_yet", irq_valid, 1'b0);
    req = '0;
    cycle();
    check("b3_valid", irq_valid, 1'b1);
    check("b3_cls", irq_cls, 2'd1);
    check("b3_ch", irq_ch, 4'd3);
    check("b3_active", cls_active, 3'b010);
    irq_ack = 1'b1;
    cycle();
    irq_ack = 1'b0;
    check("b3_ack_valid", irq_valid, 1'b0);
    check("b3_ack_pend", pend, '0);

    // Simultaneous rises in all three classes; late class-A arrival
    req[CLS_C*NCH+0] = 1'b1;
    req[CLS_B*NCH+5] = 1'b1;
    req[CLS_A*NCH+8] = 1'b1;
    cycle(2);
    req = '0;
    check("sim_a8_cls", irq_cls, 2'd0);
    check("sim_a8_ch", irq_ch, 4'd8);
    irq_ack = 1'b1;
    cycle();
    irq_ack = 1'b0;
    cycle();
    check("sim_b5_cls", irq_cls, 2'd1);
    check("sim_b5_ch", irq_ch, 4'd5);
    req[CLS_A*NCH+1] = 1'b1;
    cycle(2);
    check("hold_b5_ch", irq_ch, 4'd5);
    check("hold_b5_cls", irq_cls, 2'd1);
    irq_ack = 1'b1;
    cycle();
    irq_ack = 1'b0;
    cycle();
    check("late_a1_cls", irq_cls, 2'd0);
    check("late_a1_ch", irq_ch, 4'd1);
    req = '0;
    irq_ack = 1'b1;
    cycle(8);
    irq_ack = 1'b0;

    // Async reset while presenting; held request must not re-trigger
    req[CLS_A*NCH+0] = 1'b1;
    cycle(2);
    check("pre_rst_valid", irq_valid, 1'b1);
    @(posedge clk);
    model_clock();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", irq_valid, 1'b0);
    check("async_pend", pend, '0);
    check("async_active", cls_active, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(3);
    check("held_no_retrig", irq_valid, 1'b0);
    req = '0;

    // Randomized blocks: alternate arbitration mode, masking and ack patterns
    for (int blk = 0; blk < 8; blk++) begin
      rr_mode = blk[0];
      for (int n = 0; n < 400; n++) begin
        req = req ^ NB'($urandom & $urandom & $urandom);
        en = (blk == 2 || blk == 5) ? NCH'($urandom | $urandom) : '1;
        irq_ack = (blk == 6) ? 1'b1 : 1'($urandom_range(0, 1));
        cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/intr_ctrl_seq.md
Name: intr_ctrl_seq

Overview:
- Parametrised, clocked successor of the 27-channel combinational interrupt controller.
- NCLS request classes (class 0 highest, matching the A>B>C scheme) by NCH channels, with a per-channel enable.
- Requests are edge-captured into pending flags. One winner (class, channel) is presented through a valid/ack handshake. Within a class, arbitration is fixed-priority or round-robin.
- Sits between the peripheral request bus and the CPU interrupt input.

Parameters:
- NCH, 9, channels per class (2..32)
- NCLS, 3, number of priority classes (1..4)
- CHW, $clog2(NCH), channel-index width
- CLW, (NCLS>1)?$clog2(NCLS):1, class-index width

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  NCH  per-channel enable, shared by all classes (E vector)
- req  input  NCLS*NCH  requests; bits [c*NCH+i] = class c, channel i
- rr_mode  input  1  0 = fixed (lowest index wins), 1 = round-robin within a class
- irq_valid  output  1  interrupt presented
- irq_cls  output  CLW  class of the presented interrupt
- irq_ch  output  CHW  channel of the presented interrupt
- irq_ack  input  1  CPU accepts the presented interrupt
- cls_active  output  NCLS  bit c = class c has any pending bit (PA/PB/PC successor)
- pend  output  NCLS*NCH  raw pending flags, for debug

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. On assertion, all flops clear: req_q, pend, rr pointers (all 0), state=IDLE, irq_valid=0, irq_cls=0, irq_ch=0. cls_active is therefore 0.
- Edge capture: req_q <= req every cycle. A rise is req & ~req_q. A rise sets pend[c*NCH+i] only if en[i]=1 in that cycle; rises on disabled channels are dropped.
- Level-high req never re-triggers. A held request needs a 0 then 1 to re-raise.
- Clear: pend of the presented bit clears on the cycle irq_ack is sampled in PRESENT. If a rise on the same bit occurs that cycle, set wins and the bit stays 1.
- Eligibility: pend & replicated en. Disabling a channel masks its pend but does not clear it; re-enabling restores it.
- cls_active[c] = OR of eligible bits of class c. This is a registered-pend combinational output.
- Class selection: the lowest class index with any eligible bit wins.
- Channel selection, rr_mode=0: lowest eligible index.
- Channel selection, rr_mode=1: first eligible index searching from rr[c]+1 upward, wrapping at NCH-1 to 0. rr[c] itself is searched last.
- FSM state IDLE: irq_valid=0. If any eligible bit exists, register the winner into irq_cls/irq_ch, set irq_valid=1, go to PRESENT.
- FSM state PRESENT: irq_valid=1, and irq_cls/irq_ch are held stable regardless of newer or higher-class arrivals. Disabling the presented channel does not retract it.
- On irq_ack in PRESENT: clear the pend bit, and set rr[irq_cls]=irq_ch (the pointer is updated in both modes). Go to IDLE; irq_valid=0 the next cycle.
- irq_ack in IDLE is ignored.
- Latency: rise sampled at edge k gives pend at k, and irq_valid=1 after edge k+1 (2 cycles from request).
- Back-to-back grants: PRESENT is followed by a minimum 1 IDLE cycle.
- Throughput: one grant per 2 cycles.
- Arithmetic: the wrap search is modulo NCH; NCH need not be a power of two. Indices never exceed NCH-1.

Decomposition:
- Package intr_ctrl_pkg holds:
  - state enum {IDLE, PRESENT}
  - class constants CLS_A=0, CLS_B=1, CLS_C=2
  - function clog2_min1
- Sub-module intr_pick: NCH-wide, combinational find-first-set starting at a start index, with wrap. Outputs found and idx. Instantiated once per class, plus once for class selection with start 0.

Test Plan:
- Reset, then pulse req bit (B,3) with en=9'h1FF -> irq_valid=1 two cycles later, irq_cls=1, irq_ch=3, cls_active=3'b010. Ack -> pend cleared, irq_valid=0 next cycle.
- Simultaneous rises (C,0), (B,5), (A,8) -> grants in order A/8, B/5, C/0, each after one ack. A class-A rise arriving while B/5 is presented does not change irq_ch until ack.
- rr_mode=1, class A channels 2, 4, 7 pending and re-raised after each ack -> grant order 2, 4, 7, 2. With rr_mode=0 the order is 2, 2, 2.
- en[6]=0, rise on (A,6) -> no pend, no irq. en[6]=1 with pend(A,6) already set, then en[6]=0 -> cls_active[0]=0; re-enable -> presented.
- Ack cycle coincides with a new rise on the same bit -> pend stays 1 and the bit is re-presented after the IDLE cycle. irq_ack held high in IDLE -> no effect.
- rst_n asserted asynchronously mid-PRESENT -> irq_valid, pend and rr drop to 0 immediately. After release, a high-held req does not re-trigger.
